// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for coprocessor 0 and its consumers.
//   - CP0 register numbers (SR, Cause, EPC, PrID)
//   - Exception codes written into Cause.ExcCode
//   - Exception handler entry address, also used by next-PC selection
//   - epcOf(): EPC value captured on exception or interrupt entry
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] PRID      = 32'h0000_C0DE;

  // The victim PC is word-aligned first; a delay-slot victim restarts at
  // its branch, one word earlier.
  function automatic logic [31:0] epcOf(input logic [31:0] pc, input logic bd);
    logic [31:0] aligned;
    aligned = pc & ~32'h0000_0003;
    return bd ? (aligned - 32'd4) : aligned;
  endfunction

endpackage

// File: rtl/cp0.sv
// cp0: coprocessor 0 for the MEM stage. Holds SR, Cause, EPC and PrID,
// raises intReq for interrupts/exceptions, captures the victim PC and serves
// mfc0/mtc0/eret.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   A1           - mfc0 source register number
//   A2, DIn, WE  - mtc0 destination, data, enable
//   PC, BD       - MEM-stage instruction PC and delay-slot flag
//   ExcCode      - MEM-stage exception code (0 = none)
//   HWInt        - external interrupt lines
//   EXLClr       - eret in MEM
//   intReq       - take exception/interrupt this cycle
//   epc          - eret return address (forwarded from a same-cycle mtc0 $14)
//   DOut         - mfc0 read data
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        intReq,
  output logic [31:0] epc,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bdReg;
  logic [5:0]  ip;
  logic [4:0]  excCodeReg;
  logic [31:0] epcReg;

  logic intPending;
  logic excPending;
  logic wrSr;
  logic wrEpc;

  // Request decision uses live HWInt, not the lagging IP copy.
  assign intPending = (|(HWInt & im)) & ie & ~exl;
  assign excPending = (ExcCode != 5'd0) & ~exl;
  assign intReq     = intPending | excPending;

  assign wrSr  = WE && (A2 == REG_SR);
  assign wrEpc = WE && (A2 == REG_EPC);

  assign epc = wrEpc ? DIn : epcReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im         <= 6'd0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bdReg      <= 1'b0;
      ip         <= 6'd0;
      excCodeReg <= 5'd0;
      epcReg     <= 32'd0;
    end else begin
      ip <= HWInt;
      if (intReq) begin
        // Entry: the victim does not commit, so any mtc0 is dropped.
        exl        <= 1'b1;
        bdReg      <= BD;
        excCodeReg <= intPending ? EXC_INT : ExcCode;
        epcReg     <= epcOf(PC, BD);
      end else begin
        if (wrSr) begin
          im  <= DIn[15:10];
          ie  <= DIn[0];
          exl <= EXLClr ? 1'b0 : DIn[1];
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (wrEpc) begin
          epcReg <= DIn;
        end
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = {16'd0, im, 8'd0, exl, ie};
      REG_CAUSE: DOut = {bdReg, 15'd0, ip, 3'd0, excCodeReg, 2'd0};
      REG_EPC:   DOut = epcReg;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  A1 = 5'd0;
  logic [4:0]  A2 = 5'd0;
  logic [31:0] DIn = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] PC = 32'd0;
  logic        BD = 1'b0;
  logic [4:0]  ExcCode = 5'd0;
  logic [5:0]  HWInt = 6'd0;
  logic        EXLClr = 1'b0;
  logic        intReq;
  logic [31:0] epc;
  logic [31:0] DOut;

  int total = 0;
  int bad = 0;

  cp0 dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt), .EXLClr(EXLClr),
    .intReq(intReq), .epc(epc), .DOut(DOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic rdChk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    A1 = addr;
    #1;
    chk(tag, DOut, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; EXLClr = 1'b0; ExcCode = 5'd0; HWInt = 6'd0; BD = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rdChk("rst_sr", 5'd12, 32'h0);
    rdChk("rst_cause", 5'd13, 32'h0);
    rdChk("rst_epc", 5'd14, 32'h0);
    rdChk("rst_prid", 5'd15, 32'h0000_C0DE);
    rdChk("rst_other", 5'd3, 32'h0);
    chk("rst_intreq", {31'd0, intReq}, 32'h0);
    chk("rst_epcout", epc, 32'h0);

    // mtc0 SR = FC01
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
    #1 chk("sr_wr_noreq", {31'd0, intReq}, 32'h0);
    tick();
    idle();
    rdChk("sr_after_wr", 5'd12, 32'h0000_FC01);

    // Interrupt on HWInt[0]; misaligned PC gets aligned
    HWInt = 6'b000001; PC = 32'h0000_3003;
    #1 chk("int_req", {31'd0, intReq}, 32'h1);
    tick();
    rdChk("int_cause", 5'd13, 32'h0000_0400);
    rdChk("int_sr", 5'd12, 32'h0000_FC03);
    rdChk("int_epc", 5'd14, 32'h0000_3000);
    chk("int_masked", {31'd0, intReq}, 32'h0);

    // eret, then clear IE
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    idle();
    rdChk("eret_sr", 5'd12, 32'h0000_FC01);
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
    tick();
    idle();

    // Overflow exception in delay slot with IE=0
    ExcCode = 5'd12; PC = 32'h0000_3010; BD = 1'b1;
    #1 chk("ov_req", {31'd0, intReq}, 32'h1);
    tick();
    rdChk("ov_epc", 5'd14, 32'h0000_300C);
    rdChk("ov_cause", 5'd13, 32'h8000_0030);
    rdChk("ov_sr", 5'd12, 32'h0000_0002);
    #1 chk("ov_masked", {31'd0, intReq}, 32'h0);
    idle();

    // Cause is not writable
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    idle();
    rdChk("cause_ro", 5'd13, 32'h8000_0030);

    // mtc0 EPC together with eret: epc forwarded
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3100; EXLClr = 1'b1;
    #1 chk("epc_fwd", epc, 32'h0000_3100);
    tick();
    idle();
    rdChk("fwd_sr", 5'd12, 32'h0);
    rdChk("fwd_epc", 5'd14, 32'h0000_3100);

    // mtc0 SR with EXL=1 alongside eret: EXL cleared, IE taken
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0003; EXLClr = 1'b1;
    tick();
    idle();
    rdChk("srclr_sr", 5'd12, 32'h0000_0001);

    // Interrupt beats exception; simultaneous mtc0 EPC dropped
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
    tick();
    idle();
    HWInt = 6'b000010; ExcCode = 5'd10; PC = 32'h0000_3200;
    WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_0000;
    #1 chk("prio_req", {31'd0, intReq}, 32'h1);
    tick();
    idle();
    rdChk("prio_cause", 5'd13, 32'h0000_0800);
    rdChk("prio_epc", 5'd14, 32'h0000_3200);
    rdChk("prio_sr", 5'd12, 32'h0000_FC03);

    // Asynchronous reset between edges while EXL=1
    @(negedge clk);
    reset = 1'b1;
    rdChk("areset_sr", 5'd12, 32'h0);
    rdChk("areset_cause", 5'd13, 32'h0);
    rdChk("areset_epc", 5'd14, 32'h0);
    tick();
    reset = 1'b0;
    chk("areset_intreq", {31'd0, intReq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 for the P7 pipeline: holds SR, Cause, EPC and PrID and is the producer side of the exception interface whose consumer is next-PC selection. It sits in the MEM stage. It samples hardware interrupt lines and the MEM-stage exception code, and raises `intReq`. It captures the victim PC into EPC, serves `mfc0`/`mtc0`, and supplies the return address for `eret`.

## Interface
- `PRID`, 32'h0000_C0DE, read-only processor ID value.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `A1` input 5: `mfc0` source register number (12–15 meaningful).
- `A2` input 5: `mtc0` destination register number.
- `DIn` input 32: `mtc0` write data.
- `WE` input 1: `mtc0` in MEM this cycle.
- `PC` input 32: MEM-stage instruction PC.
- `BD` input 1: MEM-stage instruction is in a branch delay slot.
- `ExcCode` input 5: MEM-stage exception code; 0 means no exception.
- `HWInt` input 6: external interrupt lines (timer0, timer1, interrupt generator, spare).
- `EXLClr` input 1: `eret` in MEM this cycle.
- `intReq` output 1: take exception/interrupt now; NPC redirects to 32'h0000_4180.
- `epc` output 32: return address for `eret`.
- `DOut` output 32: `mfc0` read data.

## Operation
- SR (12): IM = bits [15:10], EXL = bit [1], IE = bit [0]; all other bits read 0 and are not writable.
- Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; others 0. Not writable by `mtc0`.
- EPC (14): 32-bit, fully writable by `mtc0`.
- PrID (15): constant `PRID`.
- Any other register number reads 0; writes to it are dropped.
- IP is sampled from `HWInt` every cycle, regardless of EXL.
- `intPending` = |(`HWInt` & IM) & IE & !EXL.
- `excPending` = (`ExcCode` != 0) & !EXL.
- `intReq` = `intPending` | `excPending`.
- Priority: interrupt over exception. On interrupt entry, Cause.ExcCode <= 0 (Int). Otherwise Cause.ExcCode <= `ExcCode`.
- On entry:
  - EXL <= 1.
  - Cause.BD <= `BD`.
  - EPC <= `BD` ? `PC` − 4 : `PC`, with {`PC`[31:2], 2'b00} used before the subtraction.
- Entry overrides a simultaneous `mtc0`: the write is suppressed entirely, since the faulting or interrupted instruction does not commit.
- `EXLClr`: EXL <= 0. If entry and `EXLClr` are both true in the same cycle, entry wins and EXL stays 1. This is unreachable in practice, since EXL=1 masks entry.
- `mtc0` write to SR: EXL and IE take `DIn`[1:0]. If `EXLClr` is also true, the `EXLClr` clear wins for EXL only.
- `epc` forwarding: `epc` = (`WE` && `A2`==14) ? `DIn` : EPC_reg, so `mtc0 $14` directly before `eret` returns the new value.
- `DOut` is a combinational read of the register selected by `A1`; no bypass from a same-cycle `mtc0`.

## Timing
- Reset (async): SR = 0, Cause = 0, EPC = 0. Hence `intReq` = 0 and `epc` = 0 immediately after reset, with `DOut` = 0 for `A1` ∈ {12,13,14}.
- `intReq` is combinational in the same cycle as the MEM-stage conditions; NPC and the flush logic consume it in that cycle.
- All register updates take effect on the following rising edge. EXL=1 from that edge masks further entries until `eret`.
- IP lags `HWInt` by one cycle in Cause. `intPending` uses live `HWInt`, not IP.
- Reset asserted mid-entry: state is cleared asynchronously; no partial EPC update survives.

## Structure
- Add to `lib.v`:
  - register-number macros `SR`=12, `Cause`=13, `EPC`=14, `PrID`=15;
  - ExcCode macros `Int`=0, `AdEL`=4, `AdES`=5, `RI`=10, `Ov`=12;
  - handler address macro `ExcEntry`=32'h0000_4180, shared with NPC.
- Single flat module; no sub-module. Field registers (IM, EXL, IE, BD, IP, ExcCodeReg, EPC) are held separately and concatenated on read.

## Test plan
- Reset, then read A1=12/13/14/15 -> DOut = 0, 0, 0, 32'h0000_C0DE; `intReq`=0.
- `mtc0` SR with DIn=32'h0000_FC01, then HWInt=6'b000001 -> `intReq`=1 that cycle. Next edge: Cause = 32'h0000_0400 with ExcCode 0, EXL=1, `intReq`=0.
- ExcCode=12 (Ov), PC=32'h0000_3010, BD=1 with IE=0 -> `intReq`=1; EPC=32'h0000_300C, Cause[31]=1, Cause[6:2]=12.
- HWInt enabled and ExcCode=10 in the same cycle -> Cause.ExcCode=0 (interrupt wins), and a simultaneous `mtc0` EPC is dropped.
- `mtc0` EPC with DIn=32'h0000_3100 in the same cycle as `EXLClr` -> `epc`=32'h0000_3100 combinationally; EXL=0 after the edge.
- Assert reset asynchronously between clock edges while EXL=1 -> SR/Cause/EPC read 0 before the next edge.
